// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, hold limit, one-cycle turnaround.
// Pointer advances past the owner only on release, bounding each source's wait.
module bus_grant_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  output logic [31:0] grant,
  output logic        grant_valid,
  output logic        hold_expired
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam bit                HOLD_EN  = (HOLD_MAX != 0);

  state_t            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [4:0]        gidx_q, gidx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              hexp_q, hexp_d;

  logic [4:0]        scan_idx;
  logic [4:0]        sel;
  logic              sel_found;

  // First requesting index in rotation order ptr, ptr+1, ..., ptr-1 (5-bit wrap).
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      scan_idx = ptr_q + 5'(i);
      if (!sel_found && req[scan_idx]) begin
        sel       = scan_idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    hexp_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d    = 32'h1 << sel;
          valid_d    = 1'b1;
          gidx_d     = sel;
          hold_cnt_d = HOLD_W'(1);
          state_d    = GRANT;
        end
      end

      GRANT: begin
        // A dropped request takes precedence over the hold limit on the same edge.
        if (!req[gidx_q] || (HOLD_EN && hold_cnt_q == HOLD_LIM)) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = gidx_q + 5'd1;
          state_d = TURN;
          hexp_d  = req[gidx_q];
        end else if (HOLD_EN && hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      TURN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      hexp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      hexp_q     <= hexp_d;
    end
  end

  assign grant        = grant_q;
  assign grant_valid  = valid_q;
  assign hold_expired = hexp_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Bench for bus_grant_arbiter: directed scenarios plus randomized traffic against
// an ownership/gap model, on one instance with HOLD_MAX=16 and one with HOLD_MAX=0.
module tb_bus_grant_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] req16 = '0;
  logic [31:0] req0  = '0;
  logic [31:0] grant16, grant0;
  logic        valid16, valid0, hexp16, hexp0;

  int checks = 0;
  int passes = 0;

  // Model per instance (0: HOLD_MAX=16, 1: HOLD_MAX=0): current owner, cycles held,
  // turnaround cycles still to sit out, rotation start, and expiry pulse.
  int m_owner[2] = '{-1, -1};
  int m_held[2]  = '{0, 0};
  int m_gap[2]   = '{0, 0};
  int m_ptr[2]   = '{0, 0};
  bit m_exp[2]   = '{1'b0, 1'b0};
  int m_limit[2] = '{16, 0};

  bus_grant_arbiter #(.HOLD_MAX(16), .HOLD_W(5)) u16 (
    .clk(clk), .clr(clr), .req(req16),
    .grant(grant16), .grant_valid(valid16), .hold_expired(hexp16)
  );

  bus_grant_arbiter #(.HOLD_MAX(0), .HOLD_W(5)) u0 (
    .clk(clk), .clr(clr), .req(req0),
    .grant(grant0), .grant_valid(valid0), .hold_expired(hexp0)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int d, input logic [31:0] r, input bit c);
    m_exp[d] = 1'b0;
    if (c) begin
      m_owner[d] = -1; m_held[d] = 0; m_gap[d] = 0; m_ptr[d] = 0;
    end else if (m_owner[d] >= 0) begin
      if (!r[m_owner[d]] || (m_limit[d] != 0 && m_held[d] == m_limit[d])) begin
        m_exp[d]   = r[m_owner[d]];
        m_ptr[d]   = (m_owner[d] + 1) % 32;
        m_owner[d] = -1;
        m_gap[d]   = 1;
      end else if (m_limit[d] != 0) begin
        m_held[d]++;
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 32]) begin
          m_owner[d] = (m_ptr[d] + k) % 32;
          m_held[d]  = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] mgrant(input int d);
    return (m_owner[d] >= 0) ? (32'h1 << m_owner[d]) : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, req16, clr);
    model_step(1, req0, clr);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; req16 = 32'hFFFF_FFFF; req0 = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if (grant16 !== 32'h0 || valid16 !== 1'b0 || hexp16 !== 1'b0 ||
        grant0 !== 32'h0 || valid0 !== 1'b0 || hexp0 !== 1'b0)
      $display("FAIL reset: g16=%h v16=%b e16=%b g0=%h v0=%b e0=%b, want all zero",
               grant16, valid16, hexp16, grant0, valid0, hexp0);
    else passes++;
    req16 = '0; req0 = '0;
    tick();
  endtask

  task automatic test_single_and_wrap();
    clr = 1'b0; req16 = 32'h0000_0010;
    tick();
    checks++;
    if (grant16 !== 32'h10 || valid16 !== 1'b1)
      $display("FAIL single_grant: grant=%h valid=%b, want 00000010 1", grant16, valid16);
    else passes++;
    req16 = '0;
    tick();
    checks++;
    if (grant16 !== 32'h0 || valid16 !== 1'b0 || hexp16 !== 1'b0)
      $display("FAIL single_release: grant=%h valid=%b exp=%b, want 0 0 0", grant16, valid16, hexp16);
    else passes++;
    req16 = 32'h0000_0009;
    tick();
    checks++;
    if (valid16 !== 1'b0)
      $display("FAIL turnaround: valid=%b, want 0", valid16);
    else passes++;
    tick();
    checks++;
    if (grant16 !== 32'h1 || valid16 !== 1'b1)
      $display("FAIL ptr_wrap_scan: grant=%h valid=%b, want 00000001 1", grant16, valid16);
    else passes++;
    req16 = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_rotation();
    int gcyc = 0, n = 0, gap = 0, idx = 0;
    clr = 1'b1; tick();
    clr = 1'b0; req16 = '1;
    for (int cyc = 0; cyc < 400 && n < 33; cyc++) begin
      tick();
      checks++;
      if (grant16 !== mgrant(0) || valid16 !== (m_owner[0] >= 0) || hexp16 !== m_exp[0])
        $display("FAIL rotation_cycle: grant=%h valid=%b exp=%b, want %h %b %b",
                 grant16, valid16, hexp16, mgrant(0), m_owner[0] >= 0, m_exp[0]);
      else passes++;
      if (valid16) begin
        if (gcyc == 0) begin
          for (int b = 0; b < 32; b++) if (grant16[b]) idx = b;
          checks++;
          if (idx != n % 32 || (n > 0 && gap != 2))
            $display("FAIL rotation_order: grant #%0d idx=%0d gap=%0d, want idx=%0d gap=2",
                     n, idx, gap, n % 32);
          else passes++;
          n++;
        end
        gcyc++; gap = 0;
        req16 = (gcyc == 3) ? ~grant16 : 32'hFFFF_FFFF;
      end else begin
        gcyc = 0; gap++; req16 = '1;
      end
    end
    checks++;
    if (n < 33) $display("FAIL rotation_timeout: grants=%0d, want 33", n);
    else passes++;
    req16 = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_hold_limit();
    int vcnt = 0, first_len = -1, exp_cyc = -1, regrant_cyc = -1;
    bit saw_exp = 1'b0;
    clr = 1'b1; tick();
    clr = 1'b0; req16 = 32'h8000_0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      checks++;
      if (grant16 !== mgrant(0) || valid16 !== (m_owner[0] >= 0) || hexp16 !== m_exp[0])
        $display("FAIL hold_cycle: grant=%h valid=%b exp=%b, want %h %b %b",
                 grant16, valid16, hexp16, mgrant(0), m_owner[0] >= 0, m_exp[0]);
      else passes++;
      if (valid16) begin
        vcnt++;
        if (first_len >= 0 && regrant_cyc < 0) regrant_cyc = cyc;
      end else if (vcnt > 0 && first_len < 0) first_len = vcnt;
      if (hexp16 && exp_cyc < 0) exp_cyc = cyc;
    end
    checks++;
    if (first_len != 16 || exp_cyc != 16 || regrant_cyc != 18)
      $display("FAIL hold_limit: len=%0d exp_at=%0d regrant_at=%0d, want 16 16 18",
               first_len, exp_cyc, regrant_cyc);
    else passes++;

    clr = 1'b1; tick();
    clr = 1'b0; req16 = 32'h8000_0000; vcnt = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      tick();
      checks++;
      if (grant16 !== mgrant(0) || valid16 !== (m_owner[0] >= 0) || hexp16 !== m_exp[0])
        $display("FAIL drop_at_limit_cycle: grant=%h valid=%b exp=%b, want %h %b %b",
                 grant16, valid16, hexp16, mgrant(0), m_owner[0] >= 0, m_exp[0]);
      else passes++;
      if (hexp16) saw_exp = 1'b1;
      if (valid16) vcnt++;
      if (vcnt == 16 && valid16) req16 = '0;
    end
    checks++;
    if (saw_exp !== 1'b0 || vcnt != 16)
      $display("FAIL drop_at_limit: saw_exp=%b held=%0d, want 0 16", saw_exp, vcnt);
    else passes++;
  endtask

  task automatic test_clr_mid_grant();
    bit got = 1'b0;
    clr = 1'b0; req16 = 32'h0000_0804;
    for (int cyc = 0; cyc < 8 && !got; cyc++) begin
      tick();
      if (valid16) got = 1'b1;
    end
    checks++;
    if (!got) $display("FAIL clr_mid_grant_timeout: valid=%b, want 1", valid16);
    else passes++;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    checks++;
    if (grant16 !== 32'h0 || valid16 !== 1'b0 || hexp16 !== 1'b0)
      $display("FAIL clr_mid_grant: grant=%h valid=%b exp=%b, want 0 0 0", grant16, valid16, hexp16);
    else passes++;
    clr = 1'b0;
    tick();
    checks++;
    if (grant16 !== 32'h4 || valid16 !== 1'b1)
      $display("FAIL after_clr_grant: grant=%h valid=%b, want 00000004 1", grant16, valid16);
    else passes++;
    req16 = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_unlimited_hold();
    int held = 0;
    bit saw_exp = 1'b0;
    clr = 1'b1; tick();
    clr = 1'b0; req0 = 32'h0000_0100;
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      if (grant0 === 32'h100 && valid0 === 1'b1) held++;
      if (hexp0 !== 1'b0) saw_exp = 1'b1;
    end
    checks++;
    if (held != 100 || saw_exp)
      $display("FAIL unlimited_hold: held=%0d saw_exp=%b, want 100 0", held, saw_exp);
    else passes++;
    req0 = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(3) == 0) req16 = req16 ^ (32'h1 << $urandom_range(31));
      if ($urandom_range(3) == 0) req0  = req0  ^ (32'h1 << $urandom_range(31));
      if ($urandom_range(15) == 0) req16 = $urandom;
      if ($urandom_range(15) == 0) req0  = $urandom & $urandom;
      if ($urandom_range(31) == 0) req16 = '0;
      clr = ($urandom_range(99) == 0);
      tick();
      checks++;
      if (grant16 !== mgrant(0) || valid16 !== (m_owner[0] >= 0) || hexp16 !== m_exp[0] ||
          grant0 !== mgrant(1) || valid0 !== (m_owner[1] >= 0) || hexp0 !== m_exp[1])
        $display("FAIL random_model cyc=%0d: g16=%h v16=%b e16=%b g0=%h v0=%b e0=%b, want %h %b %b %h %b %b",
                 cyc, grant16, valid16, hexp16, grant0, valid0, hexp0,
                 mgrant(0), m_owner[0] >= 0, m_exp[0], mgrant(1), m_owner[1] >= 0, m_exp[1]);
      else passes++;
      checks++;
      if (!$onehot0(grant16) || ((grant16 != 0) !== valid16) || (hexp16 && valid16) ||
          !$onehot0(grant0) || ((grant0 != 0) !== valid0) || hexp0 !== 1'b0)
        $display("FAIL random_invariant cyc=%0d: g16=%h v16=%b e16=%b g0=%h v0=%b e0=%b, want one-hot/valid-consistent",
                 cyc, grant16, valid16, hexp16, grant0, valid0, hexp0);
      else passes++;
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_and_wrap();
    test_rotation();
    test_hold_limit();
    test_clr_mid_grant();
    test_unlimited_hold();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
